// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : First-word-fall-through receive FIFO for a UART, storing each
//               character with its frame-error bit; overrun and error counting.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_LVL = 12
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_valid,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_frame_err,
    input  logic                     rd_en,
    input  logic                     clr_status,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_frame_err,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overrun,
    output logic [7:0]               err_count
);

    localparam int              c_AW     = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_DEPTH  = DEPTH[c_AW:0];
    localparam logic [c_AW:0]   c_AFULL  = AFULL_LVL[c_AW:0];

    logic [DATA_W:0]    r_mem [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_AW:0]      r_level;
    logic               r_empty;
    logic               r_full;
    logic               r_afull;
    logic               r_overrun;
    logic [7:0]         r_err_count;

    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic               w_err_inc;
    logic [c_AW:0]      w_level_nxt;

    // A pop while full frees the slot the simultaneous write lands in.
    assign w_push    = wr_valid && (!r_full || rd_en);
    assign w_pop     = rd_en && !r_empty;
    assign w_drop    = wr_valid && r_full && !rd_en;
    assign w_err_inc = w_push && wr_frame_err;

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + 1'b1;
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {wr_frame_err, wr_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_afull     <= 1'b0;
            r_overrun   <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= w_level_nxt;
            r_empty <= (w_level_nxt == '0);
            r_full  <= (w_level_nxt == c_DEPTH);
            r_afull <= (w_level_nxt >= c_AFULL);

            // A drop in the clearing cycle still leaves the flag set.
            if (clr_status) begin
                r_overrun <= w_drop;
            end else if (w_drop) begin
                r_overrun <= 1'b1;
            end

            if (clr_status) begin
                r_err_count <= {7'd0, w_err_inc};
            end else if (w_err_inc && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign {rd_frame_err, rd_data} = r_mem[r_rd_ptr];
    assign empty       = r_empty;
    assign full        = r_full;
    assign almost_full = r_afull;
    assign level       = r_level;
    assign overrun     = r_overrun;
    assign err_count   = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Directed vector table plus hand sequences for uart_rx_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int DATA_W    = 8;
    localparam int DEPTH     = 16;
    localparam int AFULL_LVL = 12;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_data = 8'd0;
    logic        wr_frame_err = 1'b0;
    logic        rd_en = 1'b0;
    logic        clr_status = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_frame_err;
    logic        empty;
    logic        full;
    logic        almost_full;
    logic [4:0]  level;
    logic        overrun;
    logic [7:0]  err_count;

    int n_pass  = 0;
    int n_total = 0;

    uart_rx_fifo #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AFULL_LVL (AFULL_LVL)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_frame_err (wr_frame_err),
        .rd_en        (rd_en),
        .clr_status   (clr_status),
        .rd_data      (rd_data),
        .rd_frame_err (rd_frame_err),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .level        (level),
        .overrun      (overrun),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wv;
        logic [7:0] wd;
        logic       wf;
        logic       re;
        logic       clr;
        logic       chk_d;
        logic [7:0] e_data;
        logic       e_ferr;
        logic       e_empty;
        logic       e_full;
        logic       e_afull;
        logic [4:0] e_level;
        logic       e_ov;
        logic [7:0] e_err;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Inputs are applied just after an edge and held for exactly one edge.
    task automatic drive(input logic wv, input logic [7:0] wd, input logic wf,
                         input logic re, input logic clr);
        wr_valid     = wv;
        wr_data      = wd;
        wr_frame_err = wf;
        rd_en        = re;
        clr_status   = clr;
        @(posedge clk);
        #1;
        wr_valid     = 1'b0;
        wr_data      = 8'd0;
        wr_frame_err = 1'b0;
        rd_en        = 1'b0;
        clr_status   = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 8'd0};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 8'd0};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 8'd0};
        vecs[3] = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 8'd1};
        vecs[4] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 8'd1};
        vecs[5] = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 8'd2};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 8'd0};
        vecs[7] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 8'd1};
        vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 8'd1};
        vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 8'd1};

        // Reset state
        #12;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_afull", 32'(almost_full), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Vector 0 is applied in the first cycle after release.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].wv, vecs[i].wd, vecs[i].wf, vecs[i].re, vecs[i].clr);
            if (vecs[i].chk_d) begin
                chk($sformatf("v%0d_data", i), 32'(rd_data), 32'(vecs[i].e_data));
                chk($sformatf("v%0d_ferr", i), 32'(rd_frame_err), 32'(vecs[i].e_ferr));
            end
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].e_empty));
            chk($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].e_full));
            chk($sformatf("v%0d_afull", i), 32'(almost_full), 32'(vecs[i].e_afull));
            chk($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].e_level));
            chk($sformatf("v%0d_ov", i), 32'(overrun), 32'(vecs[i].e_ov));
            chk($sformatf("v%0d_err", i), 32'(err_count), 32'(vecs[i].e_err));
        end

        // Fill to full, then drain in order
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            chk($sformatf("fill_level%0d", i), 32'(level), 32'(i + 1));
            chk($sformatf("fill_afull%0d", i), 32'(almost_full), 32'((i + 1) >= AFULL_LVL));
            chk($sformatf("fill_full%0d", i), 32'(full), 32'((i + 1) == DEPTH));
        end
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("drain_data%0d", i), 32'(rd_data), 32'(i));
            drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_level", 32'(level), 32'd0);

        // Overrun: drop, clear, and clear coinciding with a drop
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        chk("drop_ov", 32'(overrun), 32'd1);
        chk("drop_level", 32'(level), 32'd16);
        chk("drop_head", 32'(rd_data), 32'h00);
        drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        chk("clr_ov", 32'(overrun), 32'd0);
        drive(1'b1, 8'h56, 1'b0, 1'b0, 1'b1);
        chk("clr_drop_ov", 32'(overrun), 32'd1);
        drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        chk("clr2_ov", 32'(overrun), 32'd0);

        // Write with pop while full
        drive(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        chk("fullwr_ov", 32'(overrun), 32'd0);
        chk("fullwr_level", 32'(level), 32'd16);
        chk("fullwr_full", 32'(full), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("fullwr_data%0d", i), 32'(rd_data), (i == DEPTH - 1) ? 32'h77 : 32'(i + 1));
            drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        end
        chk("fullwr_empty", 32'(empty), 32'd1);

        // Error counter saturation
        drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        chk("err_clr", 32'(err_count), 32'd0);
        drive(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 300; i++) drive(1'b1, 8'(i), 1'b1, 1'b1, 1'b0);
        chk("err_sat", 32'(err_count), 32'd255);
        chk("err_level", 32'(level), 32'd1);
        drive(1'b1, 8'h99, 1'b1, 1'b0, 1'b1);
        chk("err_clr_wr", 32'(err_count), 32'd1);
        chk("err_clr_level", 32'(level), 32'd2);
        drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        chk("err_empty", 32'(empty), 32'd1);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0, 1'b0);
        chk("pre_rst_level", 32'(level), 32'd5);
        for (int i = 5; i < DEPTH; i++) drive(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_ov", 32'(overrun), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_ov", 32'(overrun), 32'd0);
        chk("arst_full", 32'(full), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        chk("post_rst_data", 32'(rd_data), 32'h3C);
        chk("post_rst_level", 32'(level), 32'd1);
        chk("post_rst_empty", 32'(empty), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DATA_W, default 8, received character width in bits.
REQ-002 Parameter DEPTH, default 16, entry count; power of two, >= 2.
REQ-003 Parameter AFULL_LVL, default 12, almost_full threshold; 1 <= AFULL_LVL <= DEPTH.
REQ-004 clk  input  1  clock; every register SHALL be rising-edge clocked.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 wr_valid  input  1  one-cycle character-ready pulse from the UART receiver.
REQ-007 wr_data  input  DATA_W  received character; qualified by wr_valid.
REQ-008 wr_frame_err  input  1  stop-bit error flag for wr_data; qualified by wr_valid.
REQ-009 rd_en  input  1  pop request from the consumer.
REQ-010 clr_status  input  1  synchronous clear of overrun and err_count.
REQ-011 rd_data  output  DATA_W  head character; first-word-fall-through.
REQ-012 rd_frame_err  output  1  frame-error flag stored with the head character.
REQ-013 empty  output  1  high when level == 0.
REQ-014 full  output  1  high when level == DEPTH.
REQ-015 almost_full  output  1  high when level >= AFULL_LVL.
REQ-016 level  output  log2(DEPTH)+1  current occupancy.
REQ-017 overrun  output  1  sticky flag; set when a character is dropped.
REQ-018 err_count  output  8  saturating count of accepted characters with a frame error.

Function
REQ-019 Storage SHALL be DEPTH entries of DATA_W+1 bits: character plus frame-error bit.
REQ-020 Write and read pointers SHALL be log2(DEPTH) bits wide and wrap from DEPTH-1 to 0 with no gap entry, so all DEPTH entries are usable.
REQ-021 Write accept condition: wr_valid && (!full || rd_en); accepted entry stored at the write pointer, pointer incremented.
REQ-022 Pop condition: rd_en && !empty; read pointer incremented. rd_en while empty SHALL be ignored without error.
REQ-023 rd_data and rd_frame_err SHALL present the head entry combinationally from the storage array; value is don't-care while empty.
REQ-024 Write latency: a character written into an empty FIFO at edge N SHALL appear on rd_data, with empty low, after edge N (visible in cycle N+1).
REQ-025 Simultaneous write and pop while not empty and not full: both occur, level unchanged.
REQ-026 Simultaneous write and pop while full: the head is popped, the new character is accepted, level stays DEPTH, overrun is not set.
REQ-027 Simultaneous write and rd_en while empty: the write is accepted, the pop is ignored, level becomes 1.
REQ-028 wr_valid && full && !rd_en: the character is dropped, pointers and level are unchanged, and overrun is set at that edge.
REQ-029 overrun SHALL remain high until clr_status; if clr_status and a new drop coincide, overrun ends high.
REQ-030 err_count SHALL increment on each accepted write with wr_frame_err high and saturate at 255. Dropped characters are not counted.
REQ-031 clr_status SHALL zero err_count; if an errored write coincides with clr_status, err_count ends at 1.
REQ-032 level, empty, full and almost_full SHALL be registered, or derived only from registered pointer/level state, and updated at the same edge as the pointers.

Reset
REQ-033 On reset_n low, asynchronously: pointers = 0, level = 0, empty = 1, full = 0, almost_full = 0, overrun = 0, err_count = 0.
REQ-034 Storage array contents SHALL NOT be reset.
REQ-035 Reset asserted mid-operation SHALL discard all buffered characters; the first write after release lands at entry 0.
REQ-036 Inputs in the first cycle after reset_n deasserts SHALL be honoured normally.

Verification
REQ-037 Single write 0xA5 (frame_err = 0) into empty FIFO -> next cycle: rd_data = 0xA5, empty = 0, level = 1; rd_en pulse -> empty = 1, level = 0.
REQ-038 Write 16 characters 0x00..0x0F with no reads (DEPTH 16) -> full = 1, almost_full asserted at level 12; pop all 16 -> data returned in order 0x00..0x0F.
REQ-039 FIFO full, wr_valid 0x55 without rd_en -> 0x55 dropped, overrun = 1, level = 16; clr_status -> overrun = 0.
REQ-040 FIFO full, wr_valid 0x77 with rd_en -> head popped, 0x77 becomes the last entry, overrun = 0, level = 16.
REQ-041 300 accepted writes with wr_frame_err = 1, interleaved with reads -> err_count = 255 (saturated); clr_status coinciding with an errored write -> err_count = 1.
REQ-042 After 5 writes, assert reset_n low mid-stream -> empty = 1, level = 0, overrun = 0 immediately; post-reset write 0x3C -> rd_data = 0x3C.
